ibp_update_ctrl: RTL
====================

Name: ibp_update_ctrl

Overview:
Producer side of the indirect branch predictor update interface. It accepts resolved indirect branches from commit and filters out correctly predicted and duplicate outcomes. Surviving outcomes are buffered in a small FIFO and drained one per cycle onto the predictor's update_valid/update_pc/update_target port. It also maintains the architectural last-indirect-target register that feeds the predictor lookup, and counts mispredictions.

Parameters:
DEPTH, 8, FIFO entries; power of two, minimum 2.
FILTER_CORRECT, 1, 1 = drop resolved branches whose predicted target equals the actual target; 0 = enqueue every branch.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
resolve_valid_i  input  1  resolved indirect branch presented
resolve_ready_o  output  1  block can accept a branch this cycle
resolve_pc_i  input  64  branch PC
resolve_target_i  input  64  actual target
resolve_pred_target_i  input  64  target predicted at fetch (0 = no prediction)
update_stall_i  input  1  predictor update port unavailable this cycle
update_valid_o  output  1  write the predictor this cycle
update_pc_o  output  64  PC to write
update_target_o  output  64  target to write
last_target_o  output  64  most recent resolved indirect target, drives the predictor's last_target_i
mispred_count_o  output  32  saturating mispredict count
occupancy_o  output  $clog2(DEPTH)+1  current FIFO count

Behaviour:
- Reset is rst_n, asynchronous and active-low; clock is clk. While in reset:
  - FIFO empties, so count = 0.
  - update_valid_o = 0, update_pc_o = 0, update_target_o = 0.
  - last_target_o = 0, mispred_count_o = 0, occupancy_o = 0.
  - resolve_ready_o = 1 from the first cycle after deassertion.
- Handshake: an accept occurs when resolve_valid_i && resolve_ready_o. resolve_ready_o = (count != DEPTH) and comes from registered state only. There is no combinational path from resolve_valid_i.
- On every accept, regardless of filtering:
  - last_target_o <= resolve_target_i.
  - If resolve_target_i != resolve_pred_target_i, mispred_count_o increments. It saturates at 0xFFFF_FFFF.
- Enqueue condition for an accepted branch:
  - (!FILTER_CORRECT || target != pred_target), AND
  - it is not a duplicate. A duplicate has pc and target equal to the most recently enqueued entry while that entry is still in the FIFO (count != 0).
  - The duplicate reference is a registered copy of the last enqueued pc/target plus a valid bit. The valid bit clears when the FIFO drains to empty.
- Drain: update_valid_o = (count != 0) && !update_stall_i.
  - update_pc_o and update_target_o show the head entry whenever count != 0. They hold their last value when empty.
  - The head pops on each cycle update_valid_o = 1.
  - update_stall_i holds the head unchanged; there is no timeout.
- Latency: a branch enqueued at edge N appears as update_valid_o in cycle N+1 at the earliest, with the FIFO previously empty and no stall. This gives 1 cycle of enqueue-to-update latency.
- Simultaneous enqueue and pop:
  - Both happen; count is unchanged. Legal at any count < DEPTH.
  - At count == DEPTH, ready is 0, so only the pop occurs. Ready returns the next cycle.
- Pointers wrap modulo DEPTH. occupancy_o = count.
- Reset mid-operation discards all queued updates. No partial update is emitted.

Test Plan:
- Reset release, then accept pc=0x1000, tgt=0x2000, pred=0 -> update_valid_o=1 next cycle with pc 0x1000 / tgt 0x2000; last_target_o=0x2000; mispred_count_o=1.
- Accept pc=0x1000, tgt=0x2000, pred=0x2000 with FILTER_CORRECT=1 -> no update_valid_o; last_target_o=0x2000; mispred_count_o unchanged; occupancy_o=0.
- Hold update_stall_i=1 and offer 9 distinct mispredicted branches in consecutive cycles -> 8 accepted, resolve_ready_o=0 at occupancy 8. Release stall -> 8 updates drain in order, one per cycle. Ready rises the cycle after the first pop.
- With stall=1, offer the same mispredicted pc=0x40/tgt=0x80 three times -> occupancy_o=1 and mispred_count_o=3. After draining to empty, the same branch enqueues again.
- At occupancy 3 with no stall, accept one new mispredict per cycle for 10 cycles -> occupancy stays 3, updates emerge in FIFO order, and the pointers wrap without loss.
- Assert rst_n=0 at occupancy 5 mid-drain -> update_valid_o=0 immediately; after release occupancy_o=0, last_target_o=0, mispred_count_o=0.

Source files
------------

// File: rtl/ibp_update_ctrl.sv
// Indirect branch predictor update producer.
// Filters resolved indirect branches (correct predictions, back-to-back duplicates), buffers the
// survivors in a small FIFO and drains one per cycle onto the predictor update port. Also keeps
// the last resolved indirect target and a saturating mispredict count.
module ibp_update_ctrl #(
  parameter int unsigned DEPTH          = 8,
  parameter bit          FILTER_CORRECT = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       resolve_valid_i,
  output logic                       resolve_ready_o,
  input  logic [63:0]                resolve_pc_i,
  input  logic [63:0]                resolve_target_i,
  input  logic [63:0]                resolve_pred_target_i,
  input  logic                       update_stall_i,
  output logic                       update_valid_o,
  output logic [63:0]                update_pc_o,
  output logic [63:0]                update_target_o,
  output logic [63:0]                last_target_o,
  output logic [31:0]                mispred_count_o,
  output logic [$clog2(DEPTH):0]     occupancy_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [PtrW-1:0] PtrOne = 1;
  localparam logic [CntW-1:0] CntOne = 1;
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [63:0]     mem_pc_q  [DEPTH];
  logic [63:0]     mem_tgt_q [DEPTH];

  logic            dup_valid_q, dup_valid_d;
  logic [63:0]     dup_pc_q, dup_pc_d;
  logic [63:0]     dup_tgt_q, dup_tgt_d;
  logic [63:0]     last_target_q, last_target_d;
  logic [31:0]     mispred_q, mispred_d;
  logic [63:0]     hold_pc_q, hold_pc_d;
  logic [63:0]     hold_tgt_q, hold_tgt_d;

  logic accept, is_mispred, is_dup, enq, pop, not_empty;

  // Handshake, filtering and drain decisions.
  always_comb begin
    not_empty       = (count_q != '0);
    resolve_ready_o = (count_q != CntFull);
    accept          = resolve_valid_i && resolve_ready_o;
    is_mispred      = (resolve_target_i != resolve_pred_target_i);
    // The tail entry is only a valid duplicate reference while it is still queued.
    is_dup          = dup_valid_q && not_empty &&
                      (resolve_pc_i == dup_pc_q) && (resolve_target_i == dup_tgt_q);
    enq             = accept && (!FILTER_CORRECT || is_mispred) && !is_dup;
    update_valid_o  = not_empty && !update_stall_i;
    pop             = update_valid_o;
    // Show the head while non-empty, otherwise hold the last value shown.
    update_pc_o     = not_empty ? mem_pc_q[rd_ptr_q]  : hold_pc_q;
    update_target_o = not_empty ? mem_tgt_q[rd_ptr_q] : hold_tgt_q;
    last_target_o   = last_target_q;
    mispred_count_o = mispred_q;
    occupancy_o     = count_q;
  end

  // Next-state for pointers, count, duplicate reference and status registers.
  always_comb begin
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;
    dup_valid_d   = dup_valid_q;
    dup_pc_d      = dup_pc_q;
    dup_tgt_d     = dup_tgt_q;
    last_target_d = last_target_q;
    mispred_d     = mispred_q;
    hold_pc_d     = update_pc_o;
    hold_tgt_d    = update_target_o;

    if (enq) wr_ptr_d = wr_ptr_q + PtrOne;
    if (pop) rd_ptr_d = rd_ptr_q + PtrOne;

    unique case ({enq, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase

    if (enq) begin
      dup_valid_d = 1'b1;
      dup_pc_d    = resolve_pc_i;
      dup_tgt_d   = resolve_target_i;
    end else if (count_d == '0) begin
      dup_valid_d = 1'b0;
    end

    if (accept) begin
      last_target_d = resolve_target_i;
      if (is_mispred && (mispred_q != '1)) mispred_d = mispred_q + 32'd1;
    end
  end

  // Control and status state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      dup_valid_q   <= 1'b0;
      dup_pc_q      <= '0;
      dup_tgt_q     <= '0;
      last_target_q <= '0;
      mispred_q     <= '0;
      hold_pc_q     <= '0;
      hold_tgt_q    <= '0;
    end else begin
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      dup_valid_q   <= dup_valid_d;
      dup_pc_q      <= dup_pc_d;
      dup_tgt_q     <= dup_tgt_d;
      last_target_q <= last_target_d;
      mispred_q     <= mispred_d;
      hold_pc_q     <= hold_pc_d;
      hold_tgt_q    <= hold_tgt_d;
    end
  end

  // FIFO storage; contents are only observed through count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_pc_q[wr_ptr_q]  <= resolve_pc_i;
      mem_tgt_q[wr_ptr_q] <= resolve_target_i;
    end
  end

endmodule
